// File: rtl/fios_operand_server.sv
// Operand/result server for the FIOS Montgomery multiplier fetch/push protocol.
// Optional sticky protocol-error detection is enabled by defining FIOS_OPSRV_ERR_EN.
module fios_operand_server #(
    parameter int s     = 8,
    parameter int PE_NB = s
) (
    input  logic                 clock_i,
    input  logic                 reset_n_i,
    input  logic                 wr_en_i,
    input  logic [1:0]           wr_sel_i,
    input  logic [$clog2(s)-1:0] wr_addr_i,
    input  logic [16:0]          wr_data_i,
    input  logic                 start_i,
    input  logic [$clog2(s)-1:0] rd_addr_i,
    output logic [16:0]          rd_data_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic                 mm_start_o,
    output logic [PE_NB*17-1:0]  a_o,
    input  logic                 a_shift_i,
    input  logic                 b_fetch_i,
    input  logic                 p_fetch_i,
    output logic [16:0]          b_o,
    output logic [16:0]          p_o,
    input  logic                 RES_push_i,
    input  logic [16:0]          RES_i,
    input  logic                 done_i
);

    localparam int AW = $clog2(s);
    localparam int CW = $clog2(s + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [16:0]    a_mem [s];
    logic [16:0]    b_mem [s];
    logic [16:0]    p_mem [s];
    logic [16:0]    r_mem [s];
    logic [AW-1:0]  a_base_q, a_base_d, b_ptr_q, b_ptr_d, p_ptr_q, p_ptr_d;
    logic [CW-1:0]  res_cnt_q, res_cnt_d;
    logic [16:0]    b_q, b_d, p_q, p_d, rd_data_q;
    logic           busy_q, busy_d, done_q, done_d, mm_start_q, mm_start_d;
    logic           run_s, start_entry_s, host_wr_s, push_ok_s;
    int             a_sum_s;

    assign run_s         = (state_q == ST_RUN);
    assign start_entry_s = (state_d == ST_START) && (state_q != ST_START);
    assign host_wr_s     = wr_en_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign push_ok_s     = run_s && RES_push_i && (res_cnt_q < CW'(s));
    assign a_sum_s       = int'(a_base_q) + PE_NB;

    // State register
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_i) state_d = ST_START; else state_d = ST_IDLE;
            ST_START: state_d = ST_RUN;
            ST_RUN:   if (done_i) state_d = ST_DONE; else state_d = ST_RUN;
            ST_DONE:  if (start_i) state_d = ST_START; else state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Status outputs decoded from the next state so they are registered
    always_comb begin
        busy_d     = (state_d == ST_START) || (state_d == ST_RUN);
        done_d     = (state_d == ST_DONE);
        mm_start_d = (state_d == ST_START);
    end

    // Pointer, counter and fetch-register update; requests only act in RUN
    always_comb begin
        a_base_d  = a_base_q;
        b_ptr_d   = b_ptr_q;
        p_ptr_d   = p_ptr_q;
        res_cnt_d = res_cnt_q;
        b_d       = b_q;
        p_d       = p_q;
        if (start_entry_s) begin
            a_base_d  = '0;
            b_ptr_d   = '0;
            p_ptr_d   = '0;
            res_cnt_d = '0;
        end else if (run_s) begin
            if (a_shift_i) begin
                a_base_d = (a_sum_s >= s) ? '0 : AW'(a_sum_s);
            end else begin
                a_base_d = a_base_q;
            end
            if (b_fetch_i) begin
                b_d     = b_mem[b_ptr_q];
                b_ptr_d = (int'(b_ptr_q) == s - 1) ? '0 : b_ptr_q + AW'(1);
            end else begin
                b_d = b_q;
            end
            if (p_fetch_i) begin
                p_d     = p_mem[p_ptr_q];
                p_ptr_d = (int'(p_ptr_q) == s - 1) ? '0 : p_ptr_q + AW'(1);
            end else begin
                p_d = p_q;
            end
            if (push_ok_s) begin
                res_cnt_d = res_cnt_q + CW'(1);
            end else begin
                res_cnt_d = res_cnt_q;
            end
        end else begin
            res_cnt_d = res_cnt_q;
        end
    end

    // Control and output registers
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            a_base_q   <= '0;
            b_ptr_q    <= '0;
            p_ptr_q    <= '0;
            res_cnt_q  <= '0;
            b_q        <= 17'd0;
            p_q        <= 17'd0;
            rd_data_q  <= 17'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mm_start_q <= 1'b0;
        end else begin
            a_base_q   <= a_base_d;
            b_ptr_q    <= b_ptr_d;
            p_ptr_q    <= p_ptr_d;
            res_cnt_q  <= res_cnt_d;
            b_q        <= b_d;
            p_q        <= p_d;
            rd_data_q  <= r_mem[rd_addr_i];
            busy_q     <= busy_d;
            done_q     <= done_d;
            mm_start_q <= mm_start_d;
        end
    end

    // Buffer storage: contents deliberately survive reset
    always_ff @(posedge clock_i) begin
        if (host_wr_s) begin
            case (wr_sel_i)
                2'd0:    a_mem[wr_addr_i] <= wr_data_i;
                2'd1:    b_mem[wr_addr_i] <= wr_data_i;
                2'd2:    p_mem[wr_addr_i] <= wr_data_i;
                default: ;
            endcase
        end
        if (push_ok_s) begin
            r_mem[res_cnt_q[AW-1:0]] <= RES_i;
        end
    end

    // A window: slots past the end of the operand read as zero
    always_comb begin
        a_o = '0;
        for (int k = 0; k < PE_NB; k++) begin
            if (int'(a_base_q) + k < s) begin
                a_o[17*k +: 17] = a_mem[AW'(int'(a_base_q) + k)];
            end else begin
                a_o[17*k +: 17] = 17'd0;
            end
        end
    end

`ifdef FIOS_OPSRV_ERR_EN
    logic err_q, err_d, err_set_s;

    // Sticky error: overflow push, short result count at done, or requests outside RUN
    always_comb begin
        err_set_s = (run_s && RES_push_i && (res_cnt_q == CW'(s)))
                 || (run_s && done_i && (res_cnt_d != CW'(s)))
                 || (!run_s && (a_shift_i || b_fetch_i || p_fetch_i || RES_push_i));
        if (start_entry_s) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q | err_set_s;
        end
    end

    // Error flag register
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign rd_data_o  = rd_data_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign mm_start_o = mm_start_q;
    assign b_o        = b_q;
    assign p_o        = p_q;

endmodule

// File: tb/tb_fios_operand_server.sv
// Self-checking bench for fios_operand_server (s=4, PE_NB=2) against a behavioural model.
module tb_fios_operand_server;
    localparam int S  = 4;
    localparam int PE = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wr_en, start, a_shift, b_fetch, p_fetch, res_push, done_i;
    logic [1:0]  wr_sel, wr_addr, rd_addr;
    logic [16:0] wr_data, res_word;
    logic [16:0] rd_data_o, b_o, p_o;
    logic        busy_o, done_o, err_o, mm_start_o;
    logic [33:0] a_o;

    always #5 clk = ~clk;

    fios_operand_server #(.s(S), .PE_NB(PE)) dut (
        .clock_i(clk), .reset_n_i(reset_n),
        .wr_en_i(wr_en), .wr_sel_i(wr_sel), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .start_i(start), .rd_addr_i(rd_addr), .rd_data_o(rd_data_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .mm_start_o(mm_start_o),
        .a_o(a_o), .a_shift_i(a_shift), .b_fetch_i(b_fetch), .p_fetch_i(p_fetch),
        .b_o(b_o), .p_o(p_o), .RES_push_i(res_push), .RES_i(res_word), .done_i(done_i)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int mm_cnt  = 0;

    // Reference model: phase 0 idle, 1 start, 2 run, 3 done
    int          ph, abase, bcnt, pcnt, rcnt;
    logic [16:0] mA [S];
    logic [16:0] mB [S];
    logic [16:0] mP [S];
    logic [16:0] mR [S];
    bit          mAv [S];
    bit          mRv [S];
    logic [16:0] eb, ep;
    bit          eerr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [33:0] win(input int base);
        logic [33:0] w;
        for (int k = 0; k < PE; k++)
            w[17*k +: 17] = (base + k < S) ? mA[base + k] : 17'd0;
        return w;
    endfunction

    task automatic clr();
        wr_en = 1'b0; wr_sel = 2'd0; wr_addr = 2'd0; wr_data = 17'd0;
        start = 1'b0; a_shift = 1'b0; b_fetch = 1'b0; p_fetch = 1'b0;
        res_push = 1'b0; res_word = 17'd0; done_i = 1'b0;
    endtask

    task automatic model_reset();
        ph = 0; abase = 0; bcnt = 0; pcnt = 0; rcnt = 0;
        eb = 17'd0; ep = 17'd0; eerr = 1'b0;
    endtask

    // One clock: advance the model from the current inputs, step the DUT, compare outputs
    task automatic cyc();
        int          nph;
        bit          run, ferr, allA;
        logic [16:0] erd;
        bit          erdv;
        nph = ph; run = (ph == 2); ferr = 1'b0;
        erd = mR[rd_addr]; erdv = mRv[rd_addr];
        case (ph)
            0: if (start) nph = 1;
            1: nph = 2;
            2: if (done_i) nph = 3;
            default: if (start) nph = 1;
        endcase
        if (wr_en && (ph == 0 || ph == 3)) begin
            if (wr_sel == 2'd0) begin mA[wr_addr] = wr_data; mAv[wr_addr] = 1'b1; end
            else if (wr_sel == 2'd1) mB[wr_addr] = wr_data;
            else if (wr_sel == 2'd2) mP[wr_addr] = wr_data;
        end
        if (nph == 1 && ph != 1) begin
            abase = 0; bcnt = 0; pcnt = 0; rcnt = 0; eerr = 1'b0;
        end else if (run) begin
            if (a_shift) abase = (abase + PE >= S) ? 0 : abase + PE;
            if (b_fetch) begin eb = mB[bcnt % S]; bcnt++; end
            if (p_fetch) begin ep = mP[pcnt % S]; pcnt++; end
            if (res_push) begin
                if (rcnt < S) begin mR[rcnt] = res_word; mRv[rcnt] = 1'b1; rcnt++; end
                else ferr = 1'b1;
            end
            if (done_i && rcnt != S) ferr = 1'b1;
        end else if (a_shift || b_fetch || p_fetch || res_push) begin
            ferr = 1'b1;
        end
`ifdef FIOS_OPSRV_ERR_EN
        eerr = eerr | ferr;
`endif
        ph = nph;
        @(posedge clk); #1;
        chk("busy", busy_o, (ph == 1 || ph == 2));
        chk("done", done_o, (ph == 3));
        chk("mm_start", mm_start_o, (ph == 1));
        chk("b_o", b_o, eb);
        chk("p_o", p_o, ep);
        chk("err", err_o, eerr);
        allA = mAv[0] && mAv[1] && mAv[2] && mAv[3];
        if (allA) chk("a_o", a_o, win(abase));
        if (erdv) chk("rd_data", rd_data_o, erd);
        if (mm_start_o) mm_cnt++;
    endtask

    task automatic wr(input logic [1:0] sel, input logic [1:0] addr, input logic [16:0] data);
        wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = data;
        cyc();
        clr();
    endtask

    initial begin
        logic [16:0] bseq [6];
        logic [33:0] w;
        bseq[0] = 17'd1; bseq[1] = 17'd2; bseq[2] = 17'd3;
        bseq[3] = 17'd4; bseq[4] = 17'd1; bseq[5] = 17'd2;
        clr(); rd_addr = 2'd0; reset_n = 1'b0; model_reset();
        #3;
        chk("rst_busy", busy_o, 1'b0);   chk("rst_done", done_o, 1'b0);
        chk("rst_err", err_o, 1'b0);     chk("rst_mm_start", mm_start_o, 1'b0);
        chk("rst_b", b_o, 17'd0);        chk("rst_p", p_o, 17'd0);
        chk("rst_rd", rd_data_o, 17'd0);
        @(posedge clk); #1; reset_n = 1'b1;
        cyc();

        for (int i = 0; i < S; i++) wr(2'd0, 2'(i), 17'(10 + i));
        for (int i = 0; i < S; i++) wr(2'd1, 2'(i), 17'(1 + i));
        for (int i = 0; i < S; i++) wr(2'd2, 2'(i), 17'($urandom_range(0, 17'h1FFFF)));
        w = {17'd11, 17'd10};
        chk("a_idle", a_o, w);

        start = 1'b1; cyc(); clr();
        cyc();
        chk("mm_start_pulses", mm_cnt, 1);
        for (int i = 0; i < 6; i++) begin
            b_fetch = 1'b1; p_fetch = 1'($urandom_range(0, 1));
            cyc(); clr();
            chk("b_seq", b_o, bseq[i]);
        end

        wr(2'd1, 2'd0, 17'd7);
        start = 1'b1; cyc(); clr();
        cyc();
        chk("no_restart", mm_cnt, 1);
        for (int i = 0; i < 3; i++) begin b_fetch = 1'b1; cyc(); clr(); end
        chk("b0_kept", b_o, 17'd1);

        w = {17'd11, 17'd10}; chk("a_win0", a_o, w);
        a_shift = 1'b1; cyc(); clr();
        w = {17'd13, 17'd12}; chk("a_win1", a_o, w);
        a_shift = 1'b1; cyc(); clr();
        w = {17'd11, 17'd10}; chk("a_wrap", a_o, w);

        for (int i = 0; i < S; i++) begin
            res_push = 1'b1; res_word = 17'(17'h1A + i); done_i = (i == S - 1);
            cyc(); clr();
        end
        chk("done_set", done_o, 1'b1);
        chk("busy_clr", busy_o, 1'b0);
        for (int i = 0; i < S; i++) begin
            rd_addr = 2'(i); cyc();
            chk("rd_res", rd_data_o, 17'(17'h1A + i));
        end

        res_push = 1'b1; res_word = 17'h1E; cyc(); clr();
        rd_addr = 2'd3; cyc();
        chk("r3_kept", rd_data_o, 17'h1D);
`ifdef FIOS_OPSRV_ERR_EN
        chk("err_overflow", err_o, 1'b1);
`else
        chk("err_tied", err_o, 1'b0);
`endif

        for (int i = 0; i < S; i++) begin
            wr(2'd0, 2'(i), 17'($urandom_range(0, 17'h1FFFF)));
            wr(2'd1, 2'(i), 17'($urandom_range(0, 17'h1FFFF)));
            wr(2'd2, 2'(i), 17'($urandom_range(0, 17'h1FFFF)));
        end
        start = 1'b1; cyc(); clr();
        for (int n = 0; n < 60; n++) begin
            a_shift  = ($urandom_range(0, 3) == 0);
            b_fetch  = 1'($urandom_range(0, 1));
            p_fetch  = 1'($urandom_range(0, 1));
            res_push = ($urandom_range(0, 5) == 0);
            res_word = 17'($urandom_range(0, 17'h1FFFF));
            wr_en    = ($urandom_range(0, 7) == 0);
            wr_sel   = 2'($urandom_range(0, 3));
            wr_addr  = 2'($urandom_range(0, 3));
            wr_data  = 17'($urandom_range(0, 17'h1FFFF));
            rd_addr  = 2'($urandom_range(0, 3));
            cyc(); clr();
        end
        done_i = 1'b1; cyc(); clr();
        for (int i = 0; i < S; i++) begin rd_addr = 2'(i); cyc(); end

        wr(2'd1, 2'd0, 17'd1);
        start = 1'b1; cyc(); clr();
        for (int i = 0; i < 3; i++) begin b_fetch = 1'b1; cyc(); clr(); end
        @(posedge clk); #2;
        reset_n = 1'b0; model_reset();
        #1;
        chk("midrst_busy", busy_o, 1'b0);
        chk("midrst_b", b_o, 17'd0);
        chk("midrst_mm_start", mm_start_o, 1'b0);
        reset_n = 1'b1;
        cyc();
        start = 1'b1; cyc(); clr();
        cyc();
        b_fetch = 1'b1; cyc(); clr();
        chk("restart_b", b_o, 17'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/fios_operand_server.md
# fios_operand_server

Operand/result server on the memory side of the FIOS Montgomery multiplier's fetch/push protocol. A host loads operand words, then starts the block. The block pulses start to the multiplier and answers its `a_shift`, `b_fetch` and `p_fetch` requests with operand words at fixed latency. It captures pushed result words and flags completion so the host can read the result back. The block sits between a host/register interface and one multiplier instance.

## Interface
Parameters:
- `s`, default 8: number of 17-bit words per operand.
- `PE_NB`, default `s`: number of PEs; sets the width of the `a` window.

Ports:
- `clock_i` in 1: single clock, rising edge.
- `reset_n_i` in 1: asynchronous, active-low reset.
- `wr_en_i` in 1: host write strobe.
- `wr_sel_i` in 2: target buffer for the write. 0 = A, 1 = B, 2 = P, 3 = ignored.
- `wr_addr_i` in `$clog2(s)`: word index for the write.
- `wr_data_i` in 17: word to write.
- `start_i` in 1: host start request.
- `rd_addr_i` in `$clog2(s)`: result word index for host read.
- `rd_data_o` out 17: result word `R[rd_addr_i]`, registered.
- `busy_o` out 1: high in START and RUN.
- `done_o` out 1: high in DONE.
- `err_o` out 1: sticky protocol-error flag (see Configuration).
- `mm_start_o` out 1: start pulse to the multiplier.
- `a_o` out `PE_NB*17`: current A window; slot k occupies bits `[17k+16:17k]`.
- `a_shift_i` in 1: request to advance the A window.
- `b_fetch_i`, `p_fetch_i` in 1: requests for the next B / P word.
- `b_o`, `p_o` out 17: fetched B / P word.
- `RES_push_i` in 1: result word valid this cycle.
- `RES_i` in 17: result word.
- `done_i` in 1: multiplier completion pulse.

## Operation
- States: IDLE, START, RUN, DONE.
  - IDLE -> START on `start_i`.
  - START -> RUN unconditionally after 1 cycle.
  - RUN -> DONE on `done_i`.
  - DONE -> START on `start_i`.
  - `start_i` in START or RUN is ignored.
- Host writes are accepted only in IDLE and DONE; they are ignored in START and RUN.
- Entering START clears these registers to 0: `a_base`, `b_ptr`, `p_ptr`, `res_cnt`, `err_o`.
- A window: `a_o` slot k = `A[a_base+k]` if `a_base+k < s`, else 0.
  - `a_shift_i` in RUN adds `PE_NB` to `a_base`.
  - If the new base would be `>= s`, `a_base` wraps to 0. This supports folded configurations with `PE_NB < s`.
- B stream: `b_fetch_i` in RUN loads `b_o <= B[b_ptr]` and sets `b_ptr <= (b_ptr+1) mod s`. Without a fetch, `b_o` holds its value.
- P stream: same as B, using `p_fetch_i`, `p_ptr` and `p_o`.
- Results: `RES_push_i` in RUN with `res_cnt < s` writes `R[res_cnt] <= RES_i` and increments `res_cnt`. A push with `res_cnt == s` is dropped.
- `done_i` outside RUN is ignored.
- Fetch, shift and push requests outside RUN are ignored; pointers and outputs hold.
- Simultaneous events in one cycle:
  - `b_fetch_i` and `p_fetch_i` are independent.
  - `RES_push_i` together with `done_i`: the word is captured, then the state goes to DONE.
- Reset (asynchronous, including mid-operation):
  - State goes to IDLE.
  - All pointers and counters go to 0.
  - `b_o`, `p_o`, `rd_data_o`, `busy_o`, `done_o`, `err_o`, `mm_start_o` go to 0.
  - The A, B, P and R buffer contents are not reset.

## Timing
- `mm_start_o`: exactly 1 cycle high, in the cycle after `start_i` is sampled (the START state).
- `busy_o` rises in that same cycle.
- `b_o` / `p_o`: valid 1 cycle after the fetch is sampled, and held until the next fetch.
- `a_o`: reflects the new `a_base` 1 cycle after `a_shift_i` is sampled.
- `done_o`: rises 1 cycle after `done_i` is sampled; `busy_o` falls in the same cycle.
- `rd_data_o`: equals `R[rd_addr_i]` 1 cycle after the address is presented.
- Throughput: one fetch per stream per cycle, and one push per cycle.

## Configuration
Macro: `FIOS_OPSRV_ERR_EN`.
- Defined: `err_o` is set (and stays set until the next START) by any of:
  - a push with `res_cnt == s`;
  - `done_i` in RUN with `res_cnt != s`;
  - any of `a_shift_i`, `b_fetch_i`, `p_fetch_i`, `RES_push_i` outside RUN.
- Undefined: `err_o` is tied to 0 and the error logic is absent. The port remains present.

## Test plan
All scenarios use `s=4`, `PE_NB=2`.
- Reset/start: after reset, all outputs are 0. With `B={1,2,3,4}` loaded, a start produces one `mm_start_o` pulse. Then six `b_fetch_i` pulses give `b_o` sequence 1,2,3,4,1,2 (wrap), each value appearing one cycle after its fetch.
- A window: with `A={10,11,12,13}`, `a_o` shows `{11,10}`. After `a_shift_i` it shows `{13,12}`; after a second `a_shift_i` it wraps back to `{11,10}`.
- Results: push 4 words `0x1A,0x1B,0x1C,0x1D`, with `done_i` in the same cycle as the last push. Then `done_o=1`, `busy_o=0`, and reading addresses 0..3 returns those four words.
- Overflow: a fifth push is dropped, `R[3]` stays `0x1D`, and `err_o=1` (only with `FIOS_OPSRV_ERR_EN`).
- Host writes while busy: a host write in RUN (`wr_sel_i=1, addr 0, data 7`) leaves `B[0]=1`. A `start_i` in RUN produces no second `mm_start_o`.
- Reset mid-operation: asserting `reset_n_i` low mid-RUN immediately drives `busy_o=0` and `b_o=0`. A new start then restarts with `b_o=1` after the first fetch.
